// File: rtl/vga_frame_engine_if.sv
// Video-side bundle of vga_frame_engine: painter colour in, timing, syncs and colour out.
// Latency: none, wiring only.
// Backpressure: none, the raster is free-running and consumers follow pixel_tick.
interface vga_frame_engine_if #(
    parameter int RGB_W = 3
);
    logic [RGB_W-1:0] pix_rgb_in;
    logic             test_mode;
    logic             pixel_tick;
    logic [9:0]       pixel_x;
    logic [9:0]       pixel_y;
    logic             hsync;
    logic             vsync;
    logic             video_on;
    logic [RGB_W-1:0] rgb;
    logic             frame_start;
    logic             blink;

    // The engine drives timing and colour, the painter/display side supplies colour and mode.
    modport master (
        input  pix_rgb_in, test_mode,
        output pixel_tick, pixel_x, pixel_y, hsync, vsync, video_on, rgb, frame_start, blink
    );

    modport slave (
        output pix_rgb_in, test_mode,
        input  pixel_tick, pixel_x, pixel_y, hsync, vsync, video_on, rgb, frame_start, blink
    );
endinterface

// File: rtl/vga_frame_engine.sv
// Parametrised VGA raster timing, sync/colour alignment to the painter pipeline, frame_start and frame-locked blink.
// Latency: hsync/vsync/video_on/rgb appear PIPE_LAT+1 pixel ticks after the matching pixel_x/pixel_y.
// Backpressure: none; free-running. Optional colour-bar source is enabled by defining VGA_TESTPAT_EN.
module vga_frame_engine #(
    parameter int CLK_DIV      = 4,
    parameter int H_ACT        = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACT        = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int SYNC_POL     = 0,
    parameter int PIPE_LAT     = 2,
    parameter int RGB_W        = 3,
    parameter int BLINK_FRAMES = 30
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    vga_frame_engine_if.master vif
);
    localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    // A zero-latency build still declares one (unused) stage so the array is never empty.
    localparam int DL_N    = (PIPE_LAT > 0) ? PIPE_LAT : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);
    localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_ACT  = 10'(H_ACT);
    localparam logic [9:0] Y_ACT  = 10'(V_ACT);
    localparam logic [9:0] HS_BEG = 10'(H_ACT + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACT + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACT + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACT + V_FP + V_SYNC - 1);
    localparam logic       SYNC_ACT = (SYNC_POL != 0);

    typedef struct packed {
        logic hs;
        logic vs;
        logic von;
    } ctl_t;

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic             tick_r;
    logic [9:0]       x_cnt;
    logic [9:0]       y_cnt;
    logic             x_last;
    logic             y_last;
    logic [FC_W-1:0]  frame_cnt;
    logic             blink_r;
    ctl_t             ctl_raw;
    ctl_t             ctl_dl [DL_N];
    ctl_t             ctl_d;
    logic [RGB_W-1:0] src_rgb;

    assign div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    assign x_last  = (x_cnt == X_LAST);
    assign y_last  = (y_cnt == Y_LAST);

    assign ctl_raw.hs  = (x_cnt >= HS_BEG) && (x_cnt <= HS_END);
    assign ctl_raw.vs  = (y_cnt >= VS_BEG) && (y_cnt <= VS_END);
    assign ctl_raw.von = (x_cnt < X_ACT) && (y_cnt < Y_ACT);
    assign ctl_d       = (PIPE_LAT == 0) ? ctl_raw : ctl_dl[DL_N-1];

`ifdef VGA_TESTPAT_EN
    logic [9:0]  x_dl [DL_N];
    logic [9:0]  x_d;
    logic [12:0] bar;

    assign x_d     = (PIPE_LAT == 0) ? x_cnt : x_dl[DL_N-1];
    assign bar     = {x_d, 3'b000} / 13'(H_ACT);
    assign src_rgb = vif.test_mode ? bar[RGB_W-1:0] : vif.pix_rgb_in;

    // Pixel x travels alongside the sync flags so the bar colour lines up with video_on.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            for (int i = 0; i < DL_N; i++) x_dl[i] <= '0;
        end else if (tick_r) begin
            x_dl[0] <= x_cnt;
            for (int i = 1; i < DL_N; i++) x_dl[i] <= x_dl[i-1];
        end
    end
`else
    logic unused_test_mode;

    assign unused_test_mode = vif.test_mode;
    assign src_rgb          = vif.pix_rgb_in;
`endif

    // Pixel-clock divider; the tick is registered so it stays low in the reset cycle.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            div_cnt <= '0;
            tick_r  <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            tick_r  <= (div_nxt == DIV_LAST);
        end
    end

    // Raster counters: x wraps at end of line, y advances on that same tick.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (tick_r) begin
            if (x_last) begin
                x_cnt <= '0;
                y_cnt <= y_last ? '0 : y_cnt + 1'b1;
            end else begin
                x_cnt <= x_cnt + 1'b1;
            end
        end
    end

    // Delay line matching the painter latency; reset fills it with blanking/idle.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            for (int i = 0; i < DL_N; i++) ctl_dl[i] <= '0;
        end else if (tick_r) begin
            ctl_dl[0] <= ctl_raw;
            for (int i = 1; i < DL_N; i++) ctl_dl[i] <= ctl_dl[i-1];
        end
    end

    // Output registers load the aligned flags and the painter colour once per pixel.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            vif.hsync    <= ~SYNC_ACT;
            vif.vsync    <= ~SYNC_ACT;
            vif.video_on <= 1'b0;
            vif.rgb      <= '0;
        end else if (tick_r) begin
            vif.hsync    <= ctl_d.hs ^ ~SYNC_ACT;
            vif.vsync    <= ctl_d.vs ^ ~SYNC_ACT;
            vif.video_on <= ctl_d.von;
            vif.rgb      <= ctl_d.von ? src_rgb : '0;
        end
    end

    // Blink flips every BLINK_FRAMES completed frames.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            frame_cnt <= '0;
            blink_r   <= 1'b0;
        end else if (vif.frame_start) begin
            if (frame_cnt == FC_LAST) begin
                frame_cnt <= '0;
                blink_r   <= ~blink_r;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign vif.pixel_tick  = tick_r;
    assign vif.pixel_x     = x_cnt;
    assign vif.pixel_y     = y_cnt;
    assign vif.frame_start = tick_r && x_last && y_last;
    assign vif.blink       = blink_r;
endmodule
